// File: rtl/ask_demod_pkg.sv
// ----------------------------------------------------------------------------
// ask_demod_pkg
//   Definitions shared by the ASK demodulator files and the matching
//   modulator: FSM state encoding and the default sample width / bit length.
// ----------------------------------------------------------------------------
package ask_demod_pkg;

    // Receiver lock state: HUNT waits for carrier, TRACK integrates bits.
    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    // Defaults common to modulator and demodulator.
    localparam int DEF_DW      = 8;   // sample width, two's complement
    localparam int DEF_SYM_LEN = 25;  // valid samples per bit

endpackage : ask_demod_pkg

// File: rtl/ask_abs.sv
// ----------------------------------------------------------------------------
// ask_abs
//   Registered saturating rectifier: mag = |din|, with the most negative
//   input clamped to the most positive value so the result fits DW-1 bits.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     din_i        signed input sample (two's complement)
//     din_valid_i  input qualifier
//     mag_o        rectified magnitude (unsigned), one cycle later
//     mag_v_o      registered copy of din_valid_i
// ----------------------------------------------------------------------------
module ask_abs
    import ask_demod_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din_i,
    input  logic          din_valid_i,
    output logic [DW-1:0] mag_o,
    output logic          mag_v_o
);

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] mag_d;
    logic [DW-1:0] mag_q;
    logic          mag_v_q;

    always_comb begin
        mag_d = din_i;
        if (din_i == MIN_NEG) begin
            // -2^(DW-1) has no positive counterpart; clamp instead of wrapping.
            mag_d = MAX_POS;
        end else if (din_i[DW-1]) begin
            mag_d = ~din_i + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q   <= '0;
            mag_v_q <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            mag_v_q <= din_valid_i;
        end
    end

    assign mag_o   = mag_q;
    assign mag_v_o = mag_v_q;

endmodule : ask_abs

// File: rtl/ask_demod.sv
// ----------------------------------------------------------------------------
// ask_demod
//   Non-coherent ASK demodulator: rectify, integrate-and-dump over one bit,
//   hard decision against thr. Bit timing is aligned on the first sample of
//   a carrier burst (HUNT -> TRACK); lock is dropped after LOSS_SYMS
//   consecutive '0' decisions.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     din        modulated carrier sample, signed
//     din_valid  din qualifier; low stalls the whole pipeline state
//     thr        decision threshold on integrated energy (unsigned)
//     bit_out    last decided bit, held until the next decision
//     bit_valid  one-cycle strobe when bit_out/energy update
//     energy     integrated energy of the last decided bit
//     locked     high while tracking
//   Pipeline: din -> rectifier register -> FSM/integrator register, so a
//   sample driven in cycle n produces its strobe in cycle n+2.
// ----------------------------------------------------------------------------
module ask_demod
    import ask_demod_pkg::*;
#(
    parameter  int DW        = DEF_DW,
    parameter  int SYM_LEN   = DEF_SYM_LEN,
    parameter  int MAG_TH    = 16,
    parameter  int LOSS_SYMS = 4,
    localparam int ACCW      = DW + $clog2(SYM_LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    input  logic [ACCW-1:0] thr,
    output logic            bit_out,
    output logic            bit_valid,
    output logic [ACCW-1:0] energy,
    output logic            locked
);

    localparam int CW = $clog2(SYM_LEN + 1);
    localparam int ZW = $clog2(LOSS_SYMS + 1);

    logic [DW-1:0]   mag;
    logic            mag_v;

    state_e          state_q,     state_d;
    logic [ACCW-1:0] acc_q,       acc_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [ZW-1:0]   zero_cnt_q,  zero_cnt_d;
    logic            bit_out_q,   bit_out_d;
    logic            bit_valid_q, bit_valid_d;
    logic [ACCW-1:0] energy_q,    energy_d;
    logic [ACCW-1:0] sum;

    ask_abs #(
        .DW(DW)
    ) u_abs (
        .clk        (clk),
        .rst        (rst),
        .din_i      (din),
        .din_valid_i(din_valid),
        .mag_o      (mag),
        .mag_v_o    (mag_v)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        zero_cnt_d  = zero_cnt_q;
        bit_out_d   = bit_out_q;
        energy_d    = energy_q;
        bit_valid_d = 1'b0;
        // Running sum including the current sample; on the completing
        // sample this is the energy of the bit being decided.
        sum         = acc_q + ACCW'(mag);

        if (mag_v) begin
            unique case (state_q)
                ST_HUNT: begin
                    // The detecting sample is the first sample of the bit.
                    if (ACCW'(mag) >= ACCW'(MAG_TH)) begin
                        state_d = ST_TRACK;
                        acc_d   = ACCW'(mag);
                        cnt_d   = CW'(1);
                    end
                end
                ST_TRACK: begin
                    if (cnt_q == CW'(SYM_LEN - 1)) begin
                        energy_d    = sum;
                        bit_out_d   = (sum >= thr);
                        bit_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        if (sum >= thr) begin
                            zero_cnt_d = '0;
                        end else if (zero_cnt_q == ZW'(LOSS_SYMS - 1)) begin
                            // This '0' still gets reported; lock drops with it.
                            zero_cnt_d = '0;
                            state_d    = ST_HUNT;
                        end else begin
                            zero_cnt_d = zero_cnt_q + ZW'(1);
                        end
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            acc_q       <= '0;
            cnt_q       <= '0;
            zero_cnt_q  <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            energy_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            zero_cnt_q  <= zero_cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            energy_q    <= energy_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign energy    = energy_q;
    assign locked    = (state_q == ST_TRACK);

endmodule : ask_demod
